fifo_axis_reader: RTL and testbench

//  Drain stage directly downstream of the SoC sync FIFO.
//  - Pops words through the FIFO read port: pop pulse plus pre-empty flag.
//  - Re-presents them as an AXI-Stream master with valid/ready/last.
//  - Covers the FIFO's 1-cycle read latency with a 2-entry output buffer, giving 1 beat/cycle sustained.
//  - Cuts frames of a programmable length, so the FIR/DMA consumer sees framed samples.

---
 rtl/fifo_axis_reader.sv | 116 +++++++++++
 tb/tb_fifo_axis_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_axis_reader                                                |
// | Function : Drains a 1-cycle-latency sync FIFO into a framed AXI-Stream     |
// |            master using a 2-entry skid buffer (1 beat/cycle sustained).    |
// | Options  : AXIS_READER_STALL_CNT_EN enables the saturating stall counter.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_axis_reader #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic [LEN_W-1:0] frame_len,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic             frame_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);
  localparam logic [2:0]       c_CREDIT  = 3'd2;

  logic [WIDTH-1:0] r_buf [2];
  logic             r_rd_idx;
  logic             r_wr_idx;
  logic             r_inflt;
  logic [1:0]       r_occ;
  logic [LEN_W-1:0] r_beat_idx;
  logic [LEN_W-1:0] r_cur_len;
  logic             r_frame_done;

  logic             w_out;
  logic [2:0]       w_level;
  logic [LEN_W-1:0] w_len_in;
  logic [LEN_W-1:0] w_cur_len;

  // Words already committed (buffered + in flight) minus the one leaving now;
  // a pop is only issued when its data is guaranteed a free slot on arrival.
  assign w_out    = m_tvalid & m_tready;
  assign w_level  = {1'b0, r_occ} + {2'b00, r_inflt} - {2'b00, w_out};
  assign fifo_rd  = enable & ~fifo_empty & (w_level < c_CREDIT);

  assign m_tvalid = (r_occ != 2'd0);
  assign m_tdata  = r_buf[r_rd_idx];

  assign w_len_in  = (frame_len == '0) ? c_LEN_ONE : frame_len;
  assign w_cur_len = (r_beat_idx == '0) ? w_len_in : r_cur_len;
  assign m_tlast   = m_tvalid & (r_beat_idx == (w_cur_len - c_LEN_ONE));

  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ    <= 2'd0;
      r_inflt  <= 1'b0;
      r_rd_idx <= 1'b0;
      r_wr_idx <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      r_inflt <= fifo_rd;
      r_occ   <= r_occ + {1'b0, r_inflt} - {1'b0, w_out};
      if (r_inflt) begin
        r_buf[r_wr_idx] <= fifo_rdata;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (w_out) begin
        r_rd_idx <= ~r_rd_idx;
      end
    end
  end

  // Frame length is sampled on the first beat so mid-frame edits wait a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_idx   <= '0;
      r_cur_len    <= c_LEN_ONE;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_out & m_tlast;
      if (w_out) begin
        if (r_beat_idx == '0) begin
          r_cur_len <= w_len_in;
        end
        r_beat_idx <= m_tlast ? '0 : (r_beat_idx + c_LEN_ONE);
      end
    end
  end

`ifdef AXIS_READER_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (m_tvalid & ~m_tready & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_axis_reader                                             |
// | Function : Directed bench for fifo_axis_reader with a 1-cycle FIFO model.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fifo_axis_reader;

  localparam int WIDTH = 32;
  localparam int LEN_W = 10;
  localparam int CNT_W = 16;
`ifdef AXIS_READER_STALL_CNT_EN
  localparam int EXP_STALL = 10;
`else
  localparam int EXP_STALL = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_rdata;
  logic [LEN_W-1:0] frame_len;
  logic             m_tvalid;
  logic             m_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tlast;
  logic             frame_done;
  logic [CNT_W-1:0] stall_cnt;

  fifo_axis_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .frame_len  (frame_len),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .frame_done (frame_done),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync FIFO model: data appears the cycle after the pop, cleared by rst_n.
  logic [WIDTH-1:0] mem [256];
  int wr_ptr;
  int rd_ptr;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= 0;
      fifo_rdata <= '0;
    end else if (fifo_rd) begin
      fifo_rdata <= mem[rd_ptr & 255];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  typedef struct {
    int len;         // frame_len applied
    int nwords;      // words in the FIFO
    int period;      // expected tlast period
    int frames;      // expected frame_done pulses
    int first_valid; // sampled cycle in which m_tvalid first rises
  } vec_t;

  vec_t vecs [5];
  int   n_cmp;
  int   n_fail;
  logic [WIDTH-1:0] beats_d [$];
  bit   beats_l [$];
  int   cyc, first_valid, last_beat, done_cnt, pop_cnt, unstable;
  bit   stall_prev;
  logic [WIDTH-1:0] stall_d;
  bit   stall_l;
  int   exp_l4 [10];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    beats_d.delete();
    beats_l.delete();
    cyc = 0; first_valid = 0; last_beat = 0; done_cnt = 0;
    pop_cnt = 0; unstable = 0; stall_prev = 0;
  endtask

  // One call step = sample at negedge, then advance to just after posedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (fifo_rd) pop_cnt++;
      if (frame_done) done_cnt++;
      if (m_tvalid && first_valid == 0) first_valid = cyc;
      if (m_tvalid && m_tready) begin
        beats_d.push_back(m_tdata);
        beats_l.push_back(m_tlast);
        last_beat = cyc;
      end
      if (m_tvalid && !m_tready) begin
        if (stall_prev && (m_tdata != stall_d || m_tlast != stall_l)) unstable++;
        stall_prev = 1; stall_d = m_tdata; stall_l = m_tlast;
      end else begin
        stall_prev = 0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_ptr = 0; enable = 1'b0; m_tready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_rec();
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) mem[(wr_ptr + i) & 255] = WIDTH'(i);
    wr_ptr += n;
  endtask

  task automatic verify_seq(input string tag, input int n, input int period);
    check({tag, " beats"}, beats_d.size(), n);
    for (int i = 0; i < beats_d.size() && i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), beats_d[i], i);
      check($sformatf("%s tlast[%0d]", tag, i), beats_l[i], ((i + 1) % period) == 0);
    end
  endtask

  task automatic step();
    m_tready = 1'b1;
    run(1);
    m_tready = 1'b0;
  endtask

  initial begin
    int b0, p0;
    n_cmp = 0; n_fail = 0;
    vecs[0] = '{4, 100, 4, 25, 3};
    vecs[1] = '{0, 5, 1, 5, 3};
    vecs[2] = '{1, 6, 1, 6, 3};
    vecs[3] = '{3, 9, 3, 3, 3};
    vecs[4] = '{5, 12, 5, 2, 3};
    exp_l4 = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1};

    rst_n = 1'b1; enable = 1'b0; m_tready = 1'b0; frame_len = '0; wr_ptr = 0;
    #2 rst_n = 1'b0;
    #1;
    check("reset fifo_rd", fifo_rd, 0);
    check("reset m_tvalid", m_tvalid, 0);
    check("reset m_tlast", m_tlast, 0);
    check("reset m_tdata", m_tdata, 0);
    check("reset frame_done", frame_done, 0);
    check("reset stall_cnt", stall_cnt, 0);

    // Empty FIFO: nothing may move.
    do_reset();
    enable = 1'b1; m_tready = 1'b1; frame_len = 10'd4;
    run(20);
    check("empty pops", pop_cnt, 0);
    check("empty valid", first_valid, 0);
    check("empty frame_done", done_cnt, 0);

    // Free-running streams with tready held high.
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      do_reset();
      load(vecs[v].nwords);
      frame_len = LEN_W'(vecs[v].len);
      enable = 1'b1; m_tready = 1'b1;
      run(vecs[v].nwords + 6);
      check({tag, " first_valid"}, first_valid, vecs[v].first_valid);
      check({tag, " span"}, last_beat - first_valid, vecs[v].nwords - 1);
      verify_seq(tag, vecs[v].nwords, vecs[v].period);
      check({tag, " frame_done"}, done_cnt, vecs[v].frames);
    end

    // Back-pressure for 10 cycles mid-stream.
    do_reset();
    load(100);
    frame_len = 10'd4; enable = 1'b1; m_tready = 1'b1;
    run(10);
    m_tready = 1'b0;
    b0 = beats_d.size(); p0 = pop_cnt;
    run(10);
    check("bp pops while stalled", pop_cnt - p0, 0);
    check("bp beats while stalled", beats_d.size() - b0, 0);
    check("bp unstable", unstable, 0);
    check("bp valid held", m_tvalid, 1);
    m_tready = 1'b1;
    run(100);
    verify_seq("bp", 100, 4);
    check("bp frame_done", done_cnt, 25);
    check("bp stall_cnt", stall_cnt, EXP_STALL);

    // Length 0 then 3, edited to 5 after the first beat of the len-3 frame.
    do_reset();
    load(20);
    frame_len = 10'd0; enable = 1'b1; m_tready = 1'b0;
    run(4);
    step(); step();
    frame_len = 10'd3;
    step();
    frame_len = 10'd5;
    for (int i = 0; i < 7; i++) step();
    frame_len = 10'd1;
    #1 check("len follows at frame start", m_tlast, 1);
    frame_len = 10'd5;
    #1 check("len back to 5", m_tlast, 0);
    run(3);
    check("len beats", beats_d.size(), 10);
    for (int i = 0; i < beats_d.size() && i < 10; i++) begin
      check($sformatf("len data[%0d]", i), beats_d[i], i);
      check($sformatf("len tlast[%0d]", i), beats_l[i], exp_l4[i]);
    end
    check("len frame_done", done_cnt, 4);

    // Enable drop right after a pop issued from a full buffer.
    do_reset();
    load(40);
    frame_len = 10'd3; enable = 1'b1; m_tready = 1'b1;
    run(7);
    m_tready = 1'b0;
    run(3);
    m_tready = 1'b1;
    b0 = beats_d.size();
    run(1);
    enable = 1'b0;
    p0 = pop_cnt;
    run(8);
    check("en drained beats", beats_d.size() - b0, 3);
    check("en pops while off", pop_cnt - p0, 0);
    check("en valid after drain", m_tvalid, 0);
    enable = 1'b1;
    run(40);
    verify_seq("en", 40, 3);
    check("en frame_done", done_cnt, 13);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    load(20);
    frame_len = 10'd3; enable = 1'b1; m_tready = 1'b1;
    run(7);
    check("rst pre beats", beats_d.size(), 5);
    rst_n = 1'b0; wr_ptr = 0;
    #1;
    check("rst async m_tvalid", m_tvalid, 0);
    check("rst async m_tdata", m_tdata, 0);
    check("rst async m_tlast", m_tlast, 0);
    check("rst async fifo_rd", fifo_rd, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_rec();
    load(9);
    run(15);
    verify_seq("rst", 9, 3);
    check("rst frame_done", done_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
